// File: rtl/pipelined_adder_pkg.sv
// Shared types and helpers for the segmented-carry pipelined adder.
package pipelined_adder_pkg;

    // Upper bound on DATA_WIDTH; each stage register carries full-width operand fields.
    localparam int MAX_DATA_WIDTH = 128;

    typedef struct packed {
        logic                      valid;
        logic                      carry;
        logic                      sub;
        logic                      is_signed;
        logic                      ext_a;
        logic                      ext_b;
        logic [MAX_DATA_WIDTH-1:0] sum;
        logic [MAX_DATA_WIDTH-1:0] op_a;
        logic [MAX_DATA_WIDTH-1:0] op_b;
    } stage_t;

    function automatic int seg_width(input int data_width, input int stages);
        return data_width / stages;
    endfunction

endpackage

// File: rtl/pipelined_adder_segment.sv
// Combinational carry-in/carry-out adder for one pipeline segment.
module adder_segment #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined exact adder/subtractor: the carry chain is cut into STAGES segments,
// one segment resolved per stage, with per-stage valid bits and ripple-ready flow control.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    input  logic                  sub,
    input  logic                  is_signed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH:0]   out
);

    localparam int SEG = seg_width(DATA_WIDTH, STAGES);

    if (STAGES < 1 || STAGES > 8 || (DATA_WIDTH % STAGES) != 0 || DATA_WIDTH > MAX_DATA_WIDTH)
    begin : g_bad_cfg
        $error("pipelined_adder: DATA_WIDTH must be a multiple of STAGES (1..8) and fit stage_t");
    end

    stage_t            in_beat;
    stage_t            src     [STAGES];
    stage_t            stage_d [STAGES];
    stage_t            stage_q [STAGES];
    logic [SEG-1:0]    seg_sum [STAGES];
    logic [STAGES-1:0] seg_cout;
    logic [STAGES:0]   ready;
    logic [STAGES-1:0] advance;

    // Subtraction enters as a + ~b with the +1 supplied as carry-in to segment 0.
    always_comb begin
        in_beat                      = '0;
        in_beat.valid                = in_valid;
        in_beat.carry                = sub;
        in_beat.sub                  = sub;
        in_beat.is_signed            = is_signed;
        in_beat.ext_a                = is_signed & in1[DATA_WIDTH-1];
        in_beat.ext_b                = (is_signed & in2[DATA_WIDTH-1]) ^ sub;
        in_beat.op_a[DATA_WIDTH-1:0] = in1;
        in_beat.op_b[DATA_WIDTH-1:0] = sub ? ~in2 : in2;
    end

    always_comb begin
        src[0] = in_beat;
        for (int k = 1; k < STAGES; k++) begin
            src[k] = stage_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        adder_segment #(.WIDTH(SEG)) u_seg (
            .a_i   (src[k].op_a[k*SEG +: SEG]),
            .b_i   (src[k].op_b[k*SEG +: SEG]),
            .cin_i (src[k].carry),
            .sum_o (seg_sum[k]),
            .cout_o(seg_cout[k])
        );
    end

    // The last stage folds the extension bits into the carry slot, giving out[DATA_WIDTH].
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            stage_d[k]                    = src[k];
            stage_d[k].sum[k*SEG +: SEG]  = seg_sum[k];
            stage_d[k].carry              = (k == STAGES - 1)
                                            ? (src[k].ext_a ^ src[k].ext_b ^ seg_cout[k])
                                            : seg_cout[k];
        end
    end

    always_comb begin
        ready         = '0;
        advance       = '0;
        ready[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            advance[k] = stage_q[k].valid & ready[k+1];
            ready[k]   = ~stage_q[k].valid | advance[k];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ready[k]) begin
                    stage_q[k] <= stage_d[k];
                end
            end
        end
    end

    assign in_ready  = ready[0];
    assign out_valid = stage_q[STAGES-1].valid;
    assign out       = {stage_q[STAGES-1].carry, stage_q[STAGES-1].sum[DATA_WIDTH-1:0]};

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed cases on a 32/2 instance plus
// random valid/ready traffic on 32/2, 16/4 and 64/1 instances against a queue model.
module tb_pipelined_adder;

    logic clk = 1'b0;
    logic reset;
    int   checks     = 0;
    int   failures   = 0;
    int   cyc        = 0;
    int   lastAccCyc = 0;
    int   doneCount  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Exact result from plain arithmetic: extend both operands past bit dw, add or
    // subtract at 65 bits, then keep the low dw+1 bits.
    function automatic logic [64:0] refResult(input int dw, input logic [63:0] a,
                                              input logic [63:0] b, input logic s,
                                              input logic sg);
        logic [64:0] ea;
        logic [64:0] eb;
        logic [64:0] r;
        for (int i = 0; i < 64; i++) begin
            ea[i] = (i < dw) ? a[i] : (sg & a[dw-1]);
            eb[i] = (i < dw) ? b[i] : (sg & b[dw-1]);
        end
        ea[64] = sg & a[dw-1];
        eb[64] = sg & b[dw-1];
        r = s ? (ea - eb) : (ea + eb);
        return r & ((65'd1 << (dw + 1)) - 65'd1);
    endfunction

    task automatic checkOutput(input string name, input logic [64:0] actual,
                               input logic [64:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // ---------------- 32-bit, 2-stage instance (directed + random) ----------------
    logic        inValid0, inReady0, sub0, sg0, outValid0, outReady0;
    logic [31:0] inA0, inB0;
    logic [32:0] out0;
    logic [64:0] expQ0[$];
    int          outCycles0[$];

    pipelined_adder #(.DATA_WIDTH(32), .STAGES(2)) u_dut (
        .clk(clk), .reset(reset), .in_valid(inValid0), .in_ready(inReady0),
        .in1(inA0), .in2(inB0), .sub(sub0), .is_signed(sg0),
        .out_valid(outValid0), .out_ready(outReady0), .out(out0)
    );

    always @(negedge clk) begin
        if (!reset) begin
            expQ0.delete();
        end else begin
            if (outValid0 && outReady0) begin
                outCycles0.push_back(cyc);
                if (expQ0.size() == 0)
                    checkOutput("cfg32 spurious out_valid", 65'(outValid0), 65'd0);
                else
                    checkOutput("cfg32 result", 65'(out0), expQ0.pop_front());
            end
            if (inValid0 && inReady0)
                expQ0.push_back(refResult(32, 64'(inA0), 64'(inB0), sub0, sg0));
        end
    end

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic s, input logic sg);
        bit got = 1'b0;
        inValid0 = 1'b1;
        inA0     = a;
        inB0     = b;
        sub0     = s;
        sg0      = sg;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (inReady0) begin
                got        = 1'b1;
                lastAccCyc = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
        inValid0 = 1'b0;
        if (!got) checkOutput("accept timeout", 65'(got), 65'd1);
    endtask

    task automatic runOne(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic sg, input logic [64:0] expected);
        bit seen = 1'b0;
        applyStimulus(a, b, s, sg);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (outValid0) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput({name, " seen"}, 65'(seen), 65'd1);
        checkOutput({name, " latency"}, 65'(cyc - lastAccCyc), 65'd2);
        checkOutput({name, " value"}, 65'(out0), expected);
        @(posedge clk);
        #1;
    endtask

    task automatic drain0(input string name);
        inValid0  = 1'b0;
        outReady0 = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (expQ0.size() == 0) break;
        end
        checkOutput(name, 65'(expQ0.size()), 65'd0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- random-only instances: 16/4 and 64/1 ----------------
    for (genvar g = 0; g < 2; g++) begin : g_rand
        localparam int DW = (g == 0) ? 16 : 64;
        localparam int ST = (g == 0) ? 4 : 1;
        logic          inValid, inReady, subR, sgR, outValid, outReady;
        logic [DW-1:0] inA, inB;
        logic [DW:0]   outR;
        logic [64:0]   expQ[$];

        pipelined_adder #(.DATA_WIDTH(DW), .STAGES(ST)) u_dut (
            .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady),
            .in1(inA), .in2(inB), .sub(subR), .is_signed(sgR),
            .out_valid(outValid), .out_ready(outReady), .out(outR)
        );

        always @(negedge clk) begin
            if (!reset) begin
                expQ.delete();
            end else begin
                if (outValid && outReady) begin
                    if (expQ.size() == 0)
                        checkOutput($sformatf("cfg%0d spurious out_valid", DW), 65'(outValid), 65'd0);
                    else
                        checkOutput($sformatf("cfg%0d result", DW), 65'(outR), expQ.pop_front());
                end
                if (inValid && inReady)
                    expQ.push_back(refResult(DW, 64'(inA), 64'(inB), subR, sgR));
            end
        end

        initial begin
            logic acc;
            inValid  = 1'b0;
            inA      = '0;
            inB      = '0;
            subR     = 1'b0;
            sgR      = 1'b0;
            outReady = 1'b0;
            @(posedge reset);
            @(posedge clk);
            #1;
            for (int n = 0; n < 1500; n++) begin
                @(negedge clk);
                acc = inValid && inReady;
                @(posedge clk);
                #1;
                outReady = ($urandom_range(3) != 0);
                if (acc || !inValid) begin
                    inValid = ($urandom_range(3) != 0);
                    inA     = DW'({$urandom, $urandom});
                    inB     = DW'({$urandom, $urandom});
                    subR    = 1'($urandom);
                    sgR     = 1'($urandom);
                end
            end
            inValid  = 1'b0;
            outReady = 1'b1;
            for (int n = 0; n < 40; n++) begin
                @(negedge clk);
                if (expQ.size() == 0) break;
            end
            checkOutput($sformatf("cfg%0d drain", DW), 65'(expQ.size()), 65'd0);
            doneCount++;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic acc;
        int   nAcc;
        int   startCyc;
        reset     = 1'b0;
        inValid0  = 1'b0;
        inA0      = '0;
        inB0      = '0;
        sub0      = 1'b0;
        sg0       = 1'b0;
        outReady0 = 1'b1;

        #3;
        checkOutput("reset out_valid", 65'(outValid0), 65'd0);
        checkOutput("reset out", 65'(out0), 65'd0);
        checkOutput("reset in_ready", 65'(inReady0), 65'd1);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        runOne("unsigned add carry", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 65'h1_0000_0000);
        runOne("signed sub", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 65'h1_7FFF_FFFF);
        runOne("unsigned sub borrow", 32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 65'h1_FFFF_FFFF);

        outCycles0.delete();
        startCyc = cyc;
        for (int i = 0; i < 10; i++)
            applyStimulus($urandom, $urandom, 1'(i % 2), 1'((i / 2) % 2));
        checkOutput("stream accept cycles", 65'(cyc - startCyc), 65'd10);
        drain0("stream drain");
        checkOutput("stream result count", 65'(outCycles0.size()), 65'd10);
        if (outCycles0.size() == 10)
            checkOutput("stream back-to-back", 65'(outCycles0[9] - outCycles0[0]), 65'd9);

        outReady0 = 1'b0;
        inValid0  = 1'b1;
        inA0      = $urandom;
        inB0      = $urandom;
        sub0      = 1'($urandom);
        sg0       = 1'($urandom);
        nAcc      = 0;
        for (int n = 0; n < 7; n++) begin
            @(negedge clk);
            if (outValid0 && expQ0.size() != 0)
                checkOutput("stall out hold", 65'(out0), expQ0[0]);
            acc = inReady0;
            if (acc) nAcc++;
            @(posedge clk);
            #1;
            if (acc) begin
                inA0 = $urandom;
                inB0 = $urandom;
                sub0 = 1'($urandom);
                sg0  = 1'($urandom);
            end
        end
        @(negedge clk);
        checkOutput("stall accepts", 65'(nAcc), 65'd2);
        checkOutput("stall in_ready", 65'(inReady0), 65'd0);
        checkOutput("stall out_valid", 65'(outValid0), 65'd1);
        @(posedge clk);
        #1;
        drain0("stall drain");

        applyStimulus($urandom, $urandom, 1'b0, 1'b0);
        applyStimulus($urandom, $urandom, 1'b1, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("mid reset out_valid", 65'(outValid0), 65'd0);
        checkOutput("mid reset in_ready", 65'(inReady0), 65'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            checkOutput("no stale result", 65'(outValid0), 65'd0);
        end
        @(posedge clk);
        #1;

        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            acc = inValid0 && inReady0;
            @(posedge clk);
            #1;
            outReady0 = 1'($urandom_range(1));
            if (acc || !inValid0) begin
                inValid0 = ($urandom_range(3) != 0);
                inA0     = $urandom;
                inB0     = $urandom;
                sub0     = 1'($urandom);
                sg0      = 1'($urandom);
            end
        end
        drain0("random drain");

        for (int n = 0; n < 20000; n++) begin
            if (doneCount >= 2) break;
            @(negedge clk);
        end
        checkOutput("random streams done", 65'(doneCount), 65'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
